// File: rtl/mem_ls_master.sv
`default_nettype none
// ============================================================================
// Module   : mem_ls_master
// Purpose  : Load/store initiator for the multi-cycle CPU. Accepts one
//            byte/half/word load or store per request and sequences it as
//            single-byte accesses over a byte-wide, little-endian data-memory
//            port. Loads are assembled and sign/zero-extended. Misaligned or
//            out-of-range requests are rejected without any memory access.
// Ports    : clk, rst_n (async, active low)
//            req_valid/req_ready handshake; req_we, req_size, req_signed,
//            req_addr, req_wdata request fields (latched on accept)
//            rsp_valid (1-cycle pulse), rsp_err, rsp_rdata response
//            mem_en, mem_we, mem_addr, mem_wdata, mem_rdata byte memory port
//            (read data arrives one cycle after the read strobe)
// Revision : 1.0  initial release
// ============================================================================
module mem_ls_master #(
    parameter int MEM_BYTES = 64,
    parameter int MA_W      = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_signed,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    output logic            rsp_valid,
    output logic            rsp_err,
    output logic [31:0]     rsp_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [MA_W-1:0] mem_addr,
    output logic [7:0]      mem_wdata,
    input  logic [7:0]      mem_rdata
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_XFER  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;

    logic            r_we;
    logic            r_signed;
    logic            r_err;
    logic [1:0]      r_last;      // index of the final byte (nbytes-1)
    logic [1:0]      r_idx;       // byte index currently on the memory port
    logic [31:0]     r_wdata;
    logic [31:0]     r_buf;       // load bytes collected so far
    logic [31:0]     r_rsp_rdata;
    logic [MA_W-1:0] r_base;
    logic [MA_W-1:0] r_mem_addr;
    logic [7:0]      r_mem_wdata;

    logic            w_accept;
    logic [1:0]      w_req_last;
    logic [32:0]     w_req_end;
    logic            w_req_err;
    logic [1:0]      w_idx_nx;
    logic [1:0]      w_prev_idx;
    logic [31:0]     w_assembled;
    logic            w_ext;
    logic [31:0]     w_load_result;

    assign w_accept   = req_valid & rst_n & (r_state == c_IDLE);
    assign w_idx_nx   = r_idx + 2'd1;
    assign w_prev_idx = r_idx - 2'd1;

    // Size 3 maps to 4 bytes here; it is rejected below regardless.
    assign w_req_last = (req_size == 2'd0) ? 2'd0 :
                        (req_size == 2'd1) ? 2'd1 : 2'd3;

    // 33-bit end address so a request near 2**32 cannot wrap into range.
    assign w_req_end  = {1'b0, req_addr} + 33'(w_req_last) + 33'd1;

    assign w_req_err  = (req_size == 2'd3)
                      | ((req_size == 2'd1) & req_addr[0])
                      | ((req_size == 2'd2) & (req_addr[1:0] != 2'd0))
                      | (w_req_end > 33'(MEM_BYTES));

    // In DRAIN the final byte is still on mem_rdata; merge it before extending.
    always_comb begin
        w_assembled = r_buf;
        w_assembled[{r_last, 3'b000} +: 8] = mem_rdata;
        case (r_last)
            2'd0:    w_ext = r_signed & w_assembled[7];
            2'd1:    w_ext = r_signed & w_assembled[15];
            default: w_ext = 1'b0;
        endcase
        case (r_last)
            2'd0:    w_load_result = {{24{w_ext}}, w_assembled[7:0]};
            2'd1:    w_load_result = {{16{w_ext}}, w_assembled[15:0]};
            default: w_load_result = w_assembled;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            c_IDLE: begin
                req_ready = rst_n;
                if (w_accept) begin
                    w_next_state = w_req_err ? c_RESP : c_XFER;
                end
            end
            c_XFER: begin
                mem_en = 1'b1;
                mem_we = r_we;
                if (r_idx == r_last) begin
                    w_next_state = r_we ? c_RESP : c_DRAIN;
                end
            end
            c_DRAIN: begin
                w_next_state = c_RESP;
            end
            c_RESP: begin
                rsp_valid    = 1'b1;
                w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_signed    <= 1'b0;
            r_err       <= 1'b0;
            r_last      <= 2'd0;
            r_idx       <= 2'd0;
            r_wdata     <= 32'd0;
            r_buf       <= 32'd0;
            r_rsp_rdata <= 32'd0;
            r_base      <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_we        <= req_we;
                        r_signed    <= req_signed;
                        r_last      <= w_req_last;
                        r_wdata     <= req_wdata;
                        r_idx       <= 2'd0;
                        r_buf       <= 32'd0;
                        r_rsp_rdata <= 32'd0;
                        r_err       <= w_req_err;
                        r_base      <= req_addr[MA_W-1:0];
                        // Rejected requests leave the memory port untouched.
                        if (!w_req_err) begin
                            r_mem_addr  <= req_addr[MA_W-1:0];
                            r_mem_wdata <= req_wdata[7:0];
                        end
                    end
                end
                c_XFER: begin
                    // Read data lags the strobe by one cycle: byte i-1 lands now.
                    if (!r_we && (r_idx != 2'd0)) begin
                        r_buf[{w_prev_idx, 3'b000} +: 8] <= mem_rdata;
                    end
                    if (r_idx != r_last) begin
                        r_idx       <= w_idx_nx;
                        r_mem_addr  <= r_base + MA_W'(w_idx_nx);
                        r_mem_wdata <= r_wdata[{w_idx_nx, 3'b000} +: 8];
                    end
                end
                c_DRAIN: begin
                    r_rsp_rdata <= w_load_result;
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_err   = r_err;
    assign rsp_rdata = r_rsp_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire
